// File: rtl/mem_req_pkg.sv
// Shared types for the memory request issuer: queued request bundle,
// issuer FSM states and address/register widths.
package mem_req_pkg;

    localparam int MEM_ADDR_W    = 32;
    localparam int REG_IDX_W     = 5;
    localparam int MEM_DATA_W    = 32;
    localparam int MEM_TAG_MAX_W = 16;

    typedef struct packed {
        logic                     is_store;
        logic [MEM_ADDR_W-1:0]    addr;
        logic [MEM_DATA_W-1:0]    wdata;
        logic [REG_IDX_W-1:0]     rd;
        logic [MEM_TAG_MAX_W-1:0] tag;
    } mem_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DONE,
        ST_CLR_WE,
        ST_CLR_DONE
    } issuer_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue for the memory issuer; synchronous push/pop,
// asynchronous active-high reset, power-of-two depth.
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  mem_req_t      i_data,
    input  logic          i_pop,
    output mem_req_t      o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    mem_req_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/mem_request_issuer.sv
// Queues dispatch load/store requests and issues them one at a time over the
// memory unit handshake. Optional watchdog: define MEM_REQ_TIMEOUT_EN.
module mem_request_issuer
    import mem_req_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [MEM_DATA_W-1:0] req_wdata,
    input  logic [REG_IDX_W-1:0]  req_rd,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  start_memory_read,
    output logic                  start_memory_write,
    output logic [MEM_ADDR_W-1:0] memory_address,
    output logic [MEM_DATA_W-1:0] memory_write_data,
    output logic [REG_IDX_W-1:0]  rd,
    input  logic                  load_busy,
    input  logic                  store_busy,
    input  logic                  read_memory_operation_complete,
    input  logic                  write_memory_operation_complete,
    input  logic [MEM_DATA_W-1:0] memory_read_data,
    input  logic [REG_IDX_W-1:0]  memory_write_dest,
    input  logic                  memory_write_enable,
    output logic                  memory_reset_write_enable_flag,
    input  logic                  reset_enable_flag3,
    output logic                  reset_read_memory_operation_complete,
    output logic                  reset_write_memory_operation_complete,
    input  logic                  read_memory_reset_operation_complete,
    input  logic                  write_memory_reset_operation_complete,
    output logic                  load_result_valid,
    output logic [MEM_DATA_W-1:0] load_result_data,
    output logic [REG_IDX_W-1:0]  load_result_rd,
    output logic [TAG_W-1:0]      load_result_tag,
    output logic                  store_done_valid,
    output logic [TAG_W-1:0]      store_done_tag,
    output logic                  mem_timeout_error
);

    issuer_state_e           r_state;
    issuer_state_e           w_next;
    logic                    r_is_store;
    logic [MEM_ADDR_W-1:0]   r_addr;
    logic [MEM_DATA_W-1:0]   r_wdata;
    logic [REG_IDX_W-1:0]    r_rd;
    logic [TAG_W-1:0]        r_tag;
    logic                    r_ld_valid;
    logic [MEM_DATA_W-1:0]   r_ld_data;
    logic [REG_IDX_W-1:0]    r_ld_rd;
    logic [TAG_W-1:0]        r_ld_tag;
    logic                    r_st_valid;
    logic [TAG_W-1:0]        r_st_tag;

    mem_req_t                w_push_req;
    mem_req_t                w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_fifo_count;
    logic                    w_pop;
    logic                    w_latch;
    logic                    w_load_done;
    logic                    w_store_done;
    logic                    w_tmo_hit;
    logic                    w_unused;

    assign w_push_req = '{
        is_store: req_is_store,
        addr:     req_addr,
        wdata:    req_wdata,
        rd:       req_rd,
        tag:      MEM_TAG_MAX_W'(req_tag)
    };

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (req_valid && req_ready),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    assign w_unused  = ^{w_head.tag, w_fifo_count};
    assign req_ready = !w_full;

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_latch      = 1'b0;
        w_load_done  = 1'b0;
        w_store_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_latch = 1'b1;
                    w_next  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (r_is_store ? store_busy : load_busy)
                    w_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (!r_is_store && read_memory_operation_complete
                    && memory_write_enable) begin
                    w_load_done = 1'b1;
                    w_next      = ST_CLR_WE;
                end else if (r_is_store && write_memory_operation_complete) begin
                    w_store_done = 1'b1;
                    w_next       = ST_CLR_DONE;
                end else if (w_tmo_hit) begin
                    w_next = ST_CLR_DONE;
                end
            end
            ST_CLR_WE: begin
                if (reset_enable_flag3)
                    w_next = ST_CLR_DONE;
            end
            ST_CLR_DONE: begin
                if (r_is_store ? write_memory_reset_operation_complete
                               : read_memory_reset_operation_complete) begin
                    w_pop  = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_tag      <= '0;
            r_ld_valid <= 1'b0;
            r_ld_data  <= '0;
            r_ld_rd    <= '0;
            r_ld_tag   <= '0;
            r_st_valid <= 1'b0;
            r_st_tag   <= '0;
        end else begin
            r_state    <= w_next;
            r_ld_valid <= w_load_done;
            r_st_valid <= w_store_done;
            if (w_latch) begin
                r_is_store <= w_head.is_store;
                r_addr     <= w_head.addr;
                r_wdata    <= w_head.wdata;
                r_rd       <= w_head.rd;
                r_tag      <= w_head.tag[TAG_W-1:0];
            end
            if (w_load_done) begin
                r_ld_data <= memory_read_data;
                r_ld_rd   <= memory_write_dest;
                r_ld_tag  <= r_tag;
            end
            if (w_store_done)
                r_st_tag <= r_tag;
        end
    end

    // Strobes decode straight from state so reset drops them at once.
    assign start_memory_read  = (r_state == ST_REQ) && !r_is_store;
    assign start_memory_write = (r_state == ST_REQ) && r_is_store;
    assign memory_reset_write_enable_flag = (r_state == ST_CLR_WE);
    assign reset_read_memory_operation_complete =
        (r_state == ST_CLR_DONE) && !r_is_store;
    assign reset_write_memory_operation_complete =
        (r_state == ST_CLR_DONE) && r_is_store;

    assign memory_address    = r_addr;
    assign memory_write_data = r_wdata;
    assign rd                = r_rd;
    assign load_result_valid = r_ld_valid;
    assign load_result_data  = r_ld_data;
    assign load_result_rd    = r_ld_rd;
    assign load_result_tag   = r_ld_tag;
    assign store_done_valid  = r_st_valid;
    assign store_done_tag    = r_st_tag;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_err;
    logic             w_timeout;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_timeout = (r_state == ST_WAIT_DONE) && w_tmo_hit
                       && !w_load_done && !w_store_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_DONE)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else
                r_tmo_cnt <= '0;
            if (w_timeout)
                r_tmo_err <= 1'b1;
        end
    end

    assign mem_timeout_error = r_tmo_err;
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;

    assign w_tmo_hit         = 1'b0;
    assign mem_timeout_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_request_issuer.sv
// Directed bench for mem_request_issuer with a behavioural memory unit peer.
// Timeout scenario runs only when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_request_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic [3:0]  req_tag;
    logic        start_memory_read;
    logic        start_memory_write;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [4:0]  rd;
    logic        load_busy = 1'b0;
    logic        store_busy = 1'b0;
    logic        read_memory_operation_complete = 1'b0;
    logic        write_memory_operation_complete = 1'b0;
    logic [31:0] memory_read_data = '0;
    logic [4:0]  memory_write_dest = '0;
    logic        memory_write_enable = 1'b0;
    logic        memory_reset_write_enable_flag;
    logic        reset_enable_flag3 = 1'b0;
    logic        reset_read_memory_operation_complete;
    logic        reset_write_memory_operation_complete;
    logic        read_memory_reset_operation_complete = 1'b0;
    logic        write_memory_reset_operation_complete = 1'b0;
    logic        load_result_valid;
    logic [31:0] load_result_data;
    logic [4:0]  load_result_rd;
    logic [3:0]  load_result_tag;
    logic        store_done_valid;
    logic [3:0]  store_done_tag;
    logic        mem_timeout_error;

    always #5 clk = ~clk;

    mem_request_issuer #(
        .DEPTH(4), .TAG_W(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk                                   (clk),
        .reset                                 (reset),
        .req_valid                             (req_valid),
        .req_ready                             (req_ready),
        .req_is_store                          (req_is_store),
        .req_addr                              (req_addr),
        .req_wdata                             (req_wdata),
        .req_rd                                (req_rd),
        .req_tag                               (req_tag),
        .start_memory_read                     (start_memory_read),
        .start_memory_write                    (start_memory_write),
        .memory_address                        (memory_address),
        .memory_write_data                     (memory_write_data),
        .rd                                    (rd),
        .load_busy                             (load_busy),
        .store_busy                            (store_busy),
        .read_memory_operation_complete        (read_memory_operation_complete),
        .write_memory_operation_complete       (write_memory_operation_complete),
        .memory_read_data                      (memory_read_data),
        .memory_write_dest                     (memory_write_dest),
        .memory_write_enable                   (memory_write_enable),
        .memory_reset_write_enable_flag        (memory_reset_write_enable_flag),
        .reset_enable_flag3                    (reset_enable_flag3),
        .reset_read_memory_operation_complete  (reset_read_memory_operation_complete),
        .reset_write_memory_operation_complete (reset_write_memory_operation_complete),
        .read_memory_reset_operation_complete  (read_memory_reset_operation_complete),
        .write_memory_reset_operation_complete (write_memory_reset_operation_complete),
        .load_result_valid                     (load_result_valid),
        .load_result_data                      (load_result_data),
        .load_result_rd                        (load_result_rd),
        .load_result_tag                       (load_result_tag),
        .store_done_valid                      (store_done_valid),
        .store_done_tag                        (store_done_tag),
        .mem_timeout_error                     (mem_timeout_error)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory peer state and observation records.
    logic [31:0] mem [16];
    bit          resp_en = 1'b1;
    int          ack_dly = 0;
    bit          pend_rd = 1'b0;
    bit          pend_wr = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;
    logic [4:0]  p_rd = '0;
    int          ack_cnt_r = 0;
    int          ack_cnt_w = 0;
    int          n_load = 0;
    int          n_store = 0;
    int          ev = 0;
    int          load_ev = 0;
    int          store_ev = 0;
    logic [31:0] last_data = '0;
    logic [4:0]  last_rd = '0;
    logic [3:0]  last_ltag = '0;
    logic [3:0]  last_stag = '0;
    int          clr_run = 0;
    int          last_clr_run = 0;
    int          overlap = 0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            load_busy = 0; store_busy = 0;
            read_memory_operation_complete = 0;
            write_memory_operation_complete = 0;
            memory_write_enable = 0; reset_enable_flag3 = 0;
            read_memory_reset_operation_complete = 0;
            write_memory_reset_operation_complete = 0;
            pend_rd = 0; pend_wr = 0;
            ack_cnt_r = 0; ack_cnt_w = 0; clr_run = 0;
        end else begin
            if (load_result_valid) begin
                n_load++; ev++; load_ev = ev;
                last_data = load_result_data;
                last_rd = load_result_rd;
                last_ltag = load_result_tag;
            end
            if (store_done_valid) begin
                n_store++; ev++; store_ev = ev;
                last_stag = store_done_tag;
            end
            if (reset_read_memory_operation_complete) clr_run++;
            else if (clr_run != 0) begin
                last_clr_run = clr_run; clr_run = 0;
            end
            if ((start_memory_read || start_memory_write)
                && (reset_read_memory_operation_complete
                    || reset_write_memory_operation_complete
                    || memory_reset_write_enable_flag))
                overlap++;
            load_busy = start_memory_read;
            store_busy = start_memory_write;
            if (start_memory_read) begin
                pend_rd = 1; p_addr = memory_address; p_rd = rd;
            end else if (pend_rd && resp_en) begin
                pend_rd = 0;
                read_memory_operation_complete = 1;
                memory_write_enable = 1;
                memory_read_data = mem[p_addr[3:0]];
                memory_write_dest = p_rd;
            end
            if (start_memory_write) begin
                pend_wr = 1; p_addr = memory_address;
                p_wdata = memory_write_data;
            end else if (pend_wr && resp_en) begin
                pend_wr = 0;
                mem[p_addr[3:0]] = p_wdata;
                write_memory_operation_complete = 1;
            end
            reset_enable_flag3 = memory_reset_write_enable_flag;
            if (memory_reset_write_enable_flag) memory_write_enable = 0;
            if (reset_read_memory_operation_complete) begin
                pend_rd = 0;
                if (ack_cnt_r == ack_dly) begin
                    read_memory_reset_operation_complete = 1;
                    read_memory_operation_complete = 0;
                end else begin
                    ack_cnt_r++;
                    read_memory_reset_operation_complete = 0;
                end
            end else begin
                read_memory_reset_operation_complete = 0;
                ack_cnt_r = 0;
            end
            if (reset_write_memory_operation_complete) begin
                pend_wr = 0;
                if (ack_cnt_w == ack_dly) begin
                    write_memory_reset_operation_complete = 1;
                    write_memory_operation_complete = 0;
                end else begin
                    ack_cnt_w++;
                    write_memory_reset_operation_complete = 0;
                end
            end else begin
                write_memory_reset_operation_complete = 0;
                ack_cnt_w = 0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input bit st, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r,
                        input logic [3:0] t);
        int n = 0;
        req_valid = 1; req_is_store = st; req_addr = a;
        req_wdata = d; req_rd = r; req_tag = t;
        while (!req_ready && n < 200) begin
            @(negedge clk); n++;
        end
        if (n >= 200) check("push_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_loads(input int target);
        int n = 0;
        while (n_load < target && n < 200) begin
            @(negedge clk); n++;
        end
        check("wait_loads", n_load >= target, 1);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (!start_memory_read && n < 100) begin
            @(negedge clk); n++;
        end
        check(tag, start_memory_read, 1);
    endtask

    initial begin
        int n;
        reset = 1; req_valid = 0; req_is_store = 0;
        req_addr = '0; req_wdata = '0; req_rd = '0; req_tag = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
        mem[6] = 32'hFEED_BEEF;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_starts", {start_memory_read, start_memory_write}, 0);
        check("rst_clears", {memory_reset_write_enable_flag,
              reset_read_memory_operation_complete,
              reset_write_memory_operation_complete}, 0);
        check("rst_pulses", {load_result_valid, store_done_valid}, 0);
        check("rst_addr", memory_address, 0);
        check("rst_timeout", mem_timeout_error, 0);
        reset = 0;
        @(negedge clk);

        // single load
        push(0, 32'd6, 0, 5'd5, 4'd3);
        check("lat_start_low", start_memory_read, 0);
        @(negedge clk);
        check("lat_start_high", start_memory_read, 1);
        check("req_addr_held", memory_address, 6);
        check("req_rd_held", rd, 5);
        wait_loads(1);
        check("ld1_data", last_data, 32'hFEED_BEEF);
        check("ld1_rd", last_rd, 5);
        check("ld1_tag", last_ltag, 3);
        repeat (6) @(negedge clk);
        check("ld1_once", n_load, 1);
        check("ld1_q_empty", {req_ready, start_memory_read}, 2'b10);

        // store then load, in order
        push(1, 32'd10, 32'h0000_1234, 5'd0, 4'd1);
        push(0, 32'd10, 0, 5'd7, 4'd2);
        wait_loads(2);
        check("st_count", n_store, 1);
        check("st_tag", last_stag, 1);
        check("ld2_data", last_data, 32'h0000_1234);
        check("ld2_rd", last_rd, 7);
        check("ld2_tag", last_ltag, 2);
        check("in_order", store_ev < load_ev, 1);

        // fill the queue with no responses
        resp_en = 0;
        for (int i = 0; i < 4; i++)
            push(0, 32'(i), 0, 5'(10 + i), 4'(8 + i));
        check("full_ready_low", req_ready, 0);
        req_valid = 1; req_is_store = 0; req_addr = 32'd5;
        req_rd = 5'd14; req_tag = 4'd12;
        repeat (3) @(negedge clk);
        check("fifth_held", req_ready, 0);
        resp_en = 1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk); n++;
        end
        check("pop_ready", req_ready, 1);
        check("pop_after_result", n_load, 3);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("refull", req_ready, 0);
        wait_loads(7);
        check("fifth_tag", last_ltag, 12);
        check("fifth_data", last_data, 32'hA000_0005);
        check("fifth_rd", last_rd, 14);

        // reset while a load waits for completion
        repeat (3) @(negedge clk);
        resp_en = 0;
        push(0, 32'd2, 0, 5'd3, 4'd6);
        wait_start("rst_mid_start");
        @(negedge clk);
        check("rst_mid_wait", start_memory_read, 0);
        reset = 1;
        @(negedge clk);
        check("rst_mid_strobes", {start_memory_read, start_memory_write,
              memory_reset_write_enable_flag,
              reset_read_memory_operation_complete,
              reset_write_memory_operation_complete}, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_addr", memory_address, 0);
        reset = 0;
        resp_en = 1;
        repeat (10) @(negedge clk);
        check("rst_mid_no_pulse", n_load, 7);
        check("rst_mid_idle", start_memory_read, 0);

        // delayed clear acknowledgment
        ack_dly = 5;
        push(0, 32'd3, 0, 5'd1, 4'd4);
        push(0, 32'd4, 0, 5'd2, 4'd5);
        wait_loads(9);
        repeat (10) @(negedge clk);
        check("clr_hold_cycles", last_clr_run, 6);
        check("clr_no_overlap", overlap, 0);
        check("clr_ld_data", last_data, 32'hA000_0004);
        check("clr_ld_tag", last_ltag, 5);
        ack_dly = 0;

`ifdef MEM_REQ_TIMEOUT_EN
        resp_en = 0;
        push(0, 32'd1, 0, 5'd9, 4'd7);
        wait_start("tmo_start");
        @(negedge clk);
        n = 0;
        while (!mem_timeout_error && n < 100) begin
            @(negedge clk); n++;
        end
        check("tmo_cycles", n, 16);
        repeat (4) @(negedge clk);
        resp_en = 1;
        push(0, 32'd5, 0, 5'd4, 4'd9);
        wait_loads(10);
        check("tmo_dropped", n_load, 10);
        check("tmo_next_tag", last_ltag, 9);
        check("tmo_sticky", mem_timeout_error, 1);
`else
        check("no_timeout", mem_timeout_error, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
